regfile_arbiter: RTL and testbench
==================================

// Module: regfile_arbiter
// PURPOSE
//  Shares the single 8x16 register file between two requesters: port 0 = core
//  pipeline, port 1 = debug/monitor unit. Sequences each access through the
//  file's 1-cycle registered-read timing. Returns A/B read data with a 1-cycle
//  ack pulse. Sits between the requesters and the register file's
//  enable/select/write inputs.
// PARAMETERS
//  DATA_W    16  data width of rD_in and read data
//  SEL_W     3   register select width (8 registers)
//  RR_EN     1   1 = round-robin on contention; 0 = fixed priority, port 0 wins
// PORTS
//  I_clk          in   1        clock, rising edge
//  I_reset        in   1        asynchronous active-high reset
//  I_req[1:0]     in   2        per-port request; hold with command stable until ack
//  I_rD_sel0/1    in   SEL_W    per-port write-destination select
//  I_rA_sel0/1    in   SEL_W    per-port read-A select
//  I_rB_sel0/1    in   SEL_W    per-port read-B select
//  I_rD_in0/1     in   DATA_W   per-port write data
//  I_wr0/1        in   1        per-port write request
//  I_wr_pos0/1    in   2        0=full word, 1=low byte, 2=high byte, 3=no write
//  I_rf_rA_out    in   DATA_W   register-file read port A
//  I_rf_rB_out    in   DATA_W   register-file read port B
//  O_rf_enable    out  1        register-file enable
//  O_rf_rD_select out  SEL_W    register-file write select
//  O_rf_rA_select out  SEL_W    register-file read-A select
//  O_rf_rB_select out  SEL_W    register-file read-B select
//  O_rf_rD_in     out  DATA_W   register-file write data
//  O_rf_rD_write  out  1        register-file write strobe
//  O_rf_write_pos out  2        register-file write position
//  O_ack[1:0]     out  2        one-hot ack pulse, 1 cycle, to the granted port
//  O_rA_data      out  DATA_W   captured read-A data; valid while ack high
//  O_rB_data      out  DATA_W   captured read-B data; valid while ack high
//  O_busy         out  1        high whenever state != IDLE
// BEHAVIOUR
//  FSM: IDLE -> ISSUE -> CAPTURE -> ACK -> (ISSUE if another eligible req, else IDLE).
//  - IDLE/ACK: arbitrate at the clock edge.
//    - Eligible = I_req, excluding the port acked this cycle while in ACK.
//    - On a win: latch that port's sel/data/wr/wr_pos, record grant, go to ISSUE.
//  - ISSUE (1 cycle): O_rf_enable=1; all rf outputs from the latched command.
//    O_rf_rD_write = latched wr.
//  - CAPTURE (1 cycle): O_rf_enable=0. Register I_rf_rA_out/I_rf_rB_out into
//    O_rA_data/O_rB_data at the closing edge.
//  - ACK (1 cycle): O_ack[grant]=1; data held stable until the next capture.
//  - Latency: request sampled in IDLE at edge k -> ack high in cycle k+3.
//    Back-to-back grants: one access every 3 cycles.
//  - Contention with RR_EN=1: the port not granted last wins.
//    last_grant resets to 1, so port 0 wins first.
//  - Contention with RR_EN=0: port 0 always wins; port 1 may starve (by design).
//  - Read and write of the same register in one access: read data is the
//    PRE-write value. The new value is visible to the next access.
//  - O_rf_* outputs are 0 and O_rf_enable=0 in every state except ISSUE.
//  - Requester dropping req before ack: access still completes and acks.
//    No cancel path.
//  - Reset (async, any state):
//    - state=IDLE, O_ack=0, O_busy=0, O_rA_data=O_rB_data=0, last_grant=1,
//      latched command=0.
//    - O_rf_enable=0 immediately, so a pending ISSUE write is dropped.
//    - The register file's own (synchronous) reset clears its contents.
// TESTING
//  1 Single read: port0 req rA=2,rB=5 (r2=0x1234, r5=0xBEEF)
//    -> ack[0] at k+3, O_rA_data=0x1234, O_rB_data=0xBEEF.
//  2 Byte writes: port1 wr r3 pos1 0x00AA, then pos2 0xCC00 (r3 was 0x1111)
//    -> r3=0x11AA, then 0xCCAA; pos3 leaves r3 unchanged.
//  3 Contention, RR_EN=1: both req held for 4 grants -> acks 0,1,0,1,
//    3 cycles apart, O_busy continuously high.
//  4 Contention, RR_EN=0: both req held -> only ack[0] while port0 requests;
//    port1 acked 3 cycles after port0 drops req.
//  5 Read-during-write: port0 wr r4=0x5555 and rA=r4 (old 0x0001)
//    -> O_rA_data=0x0001; next read of r4 -> 0x5555.
//  6 Reset in ISSUE with write to r6 -> no rf enable after reset,
//    O_ack=0, state IDLE, r6 not written.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if
//   Bundles the requester-side and register-file-side signals of
//   regfile_arbiter. Signal names match the original flat port list.
//   slave  : view used by the arbiter (takes I_*, drives O_*)
//   master : view used by the surrounding requesters and register file
//   Requester side : I_req, I_rD_sel0/1, I_rA_sel0/1, I_rB_sel0/1,
//                    I_rD_in0/1, I_wr0/1, I_wr_pos0/1, O_ack, O_rA_data,
//                    O_rB_data, O_busy
//   Reg-file side  : I_rf_rA_out, I_rf_rB_out, O_rf_enable, O_rf_rD_select,
//                    O_rf_rA_select, O_rf_rB_select, O_rf_rD_in,
//                    O_rf_rD_write, O_rf_write_pos
interface regfile_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
);
    logic [1:0]        I_req;
    logic [SEL_W-1:0]  I_rD_sel0, I_rD_sel1;
    logic [SEL_W-1:0]  I_rA_sel0, I_rA_sel1;
    logic [SEL_W-1:0]  I_rB_sel0, I_rB_sel1;
    logic [DATA_W-1:0] I_rD_in0, I_rD_in1;
    logic              I_wr0, I_wr1;
    logic [1:0]        I_wr_pos0, I_wr_pos1;
    logic [DATA_W-1:0] I_rf_rA_out, I_rf_rB_out;

    logic              O_rf_enable;
    logic [SEL_W-1:0]  O_rf_rD_select, O_rf_rA_select, O_rf_rB_select;
    logic [DATA_W-1:0] O_rf_rD_in;
    logic              O_rf_rD_write;
    logic [1:0]        O_rf_write_pos;
    logic [1:0]        O_ack;
    logic [DATA_W-1:0] O_rA_data, O_rB_data;
    logic              O_busy;

    modport slave (
        input  I_req, I_rD_sel0, I_rD_sel1, I_rA_sel0, I_rA_sel1,
               I_rB_sel0, I_rB_sel1, I_rD_in0, I_rD_in1, I_wr0, I_wr1,
               I_wr_pos0, I_wr_pos1, I_rf_rA_out, I_rf_rB_out,
        output O_rf_enable, O_rf_rD_select, O_rf_rA_select, O_rf_rB_select,
               O_rf_rD_in, O_rf_rD_write, O_rf_write_pos, O_ack,
               O_rA_data, O_rB_data, O_busy
    );

    modport master (
        output I_req, I_rD_sel0, I_rD_sel1, I_rA_sel0, I_rA_sel1,
               I_rB_sel0, I_rB_sel1, I_rD_in0, I_rD_in1, I_wr0, I_wr1,
               I_wr_pos0, I_wr_pos1, I_rf_rA_out, I_rf_rB_out,
        input  O_rf_enable, O_rf_rD_select, O_rf_rA_select, O_rf_rB_select,
               O_rf_rD_in, O_rf_rD_write, O_rf_write_pos, O_ack,
               O_rA_data, O_rB_data, O_busy
    );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Shares one registered-read register file between two requesters
//   (port 0 = core pipeline, port 1 = debug/monitor). Each access runs
//   IDLE/ACK -> ISSUE -> CAPTURE -> ACK: the command is driven to the file
//   for one cycle, the file's registered read data is captured one cycle
//   later, then a one-cycle ack pulse goes to the granted port.
//   Parameters: DATA_W data width, SEL_W register select width,
//               RR_EN 1 = round-robin on contention, 0 = port 0 priority.
//   Ports: I_clk  rising-edge clock
//          I_reset asynchronous active-high reset
//          bus    regfile_arbiter_if.slave (requester + register-file signals)
module regfile_arbiter #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3,
    parameter bit RR_EN  = 1'b1
) (
    input logic              I_clk,
    input logic              I_reset,
    regfile_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic              grant, last_grant;
    logic [SEL_W-1:0]  cmd_rd_sel, cmd_ra_sel, cmd_rb_sel;
    logic [DATA_W-1:0] cmd_rd_in;
    logic              cmd_wr;
    logic [1:0]        cmd_wr_pos;
    logic [DATA_W-1:0] ra_data, rb_data;

    logic [1:0]        acked;
    logic [1:0]        eligible;
    logic              win_valid, win_port;

    // Arbitration. In ACK the acked port's request still reflects the
    // command just completed, so on its own it is not re-granted. When both
    // ports request, the contention policy alone picks the winner; under
    // round-robin that is always the port not just served.
    always_comb begin
        acked     = '0;
        win_valid = 1'b0;
        win_port  = 1'b0;
        if (state == ST_ACK) begin
            acked[grant] = 1'b1;
        end
        eligible = bus.I_req & ~acked;
        if (state == ST_IDLE || state == ST_ACK) begin
            if (&bus.I_req) begin
                win_valid = 1'b1;
                win_port  = RR_EN ? ~last_grant : 1'b0;
            end else begin
                win_valid = |eligible;
                win_port  = eligible[1];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (win_valid) state_nx = ST_ISSUE;
            ST_ISSUE:   state_nx = ST_CAPTURE;
            ST_CAPTURE: state_nx = ST_ACK;
            ST_ACK:     state_nx = win_valid ? ST_ISSUE : ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cmd_rd_sel <= '0;
            cmd_ra_sel <= '0;
            cmd_rb_sel <= '0;
            cmd_rd_in  <= '0;
            cmd_wr     <= 1'b0;
            cmd_wr_pos <= '0;
            ra_data    <= '0;
            rb_data    <= '0;
        end else begin
            state <= state_nx;
            if (win_valid) begin
                grant      <= win_port;
                last_grant <= win_port;
                cmd_rd_sel <= win_port ? bus.I_rD_sel1 : bus.I_rD_sel0;
                cmd_ra_sel <= win_port ? bus.I_rA_sel1 : bus.I_rA_sel0;
                cmd_rb_sel <= win_port ? bus.I_rB_sel1 : bus.I_rB_sel0;
                cmd_rd_in  <= win_port ? bus.I_rD_in1  : bus.I_rD_in0;
                cmd_wr     <= win_port ? bus.I_wr1     : bus.I_wr0;
                cmd_wr_pos <= win_port ? bus.I_wr_pos1 : bus.I_wr_pos0;
            end
            if (state == ST_CAPTURE) begin
                ra_data <= bus.I_rf_rA_out;
                rb_data <= bus.I_rf_rB_out;
            end
        end
    end

    // Register-file drive is decoded from state so an async reset removes
    // the enable at once and a pending write never reaches the file.
    always_comb begin
        bus.O_rf_enable    = 1'b0;
        bus.O_rf_rD_select = '0;
        bus.O_rf_rA_select = '0;
        bus.O_rf_rB_select = '0;
        bus.O_rf_rD_in     = '0;
        bus.O_rf_rD_write  = 1'b0;
        bus.O_rf_write_pos = '0;
        if (state == ST_ISSUE) begin
            bus.O_rf_enable    = 1'b1;
            bus.O_rf_rD_select = cmd_rd_sel;
            bus.O_rf_rA_select = cmd_ra_sel;
            bus.O_rf_rB_select = cmd_rb_sel;
            bus.O_rf_rD_in     = cmd_rd_in;
            bus.O_rf_rD_write  = cmd_wr;
            bus.O_rf_write_pos = cmd_wr_pos;
        end
    end

    assign bus.O_ack     = acked;
    assign bus.O_busy    = (state != ST_IDLE);
    assign bus.O_rA_data = ra_data;
    assign bus.O_rB_data = rb_data;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter
//   Directed bench for regfile_arbiter. Instance A uses round-robin,
//   instance B fixed priority. Each instance talks to a small behavioural
//   8x16 register file with registered reads and a synchronous reset.
module tb_regfile_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    regfile_arbiter_if #(.DATA_W(16), .SEL_W(3)) ifa ();
    regfile_arbiter_if #(.DATA_W(16), .SEL_W(3)) ifb ();

    regfile_arbiter #(.DATA_W(16), .SEL_W(3), .RR_EN(1'b1)) dut_rr (
        .I_clk(clk), .I_reset(rst), .bus(ifa)
    );
    regfile_arbiter #(.DATA_W(16), .SEL_W(3), .RR_EN(1'b0)) dut_fp (
        .I_clk(clk), .I_reset(rst), .bus(ifb)
    );

    logic [15:0] rfa [8];
    logic [15:0] rfb [8];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rfa[i] <= '0;
            ifa.I_rf_rA_out <= '0;
            ifa.I_rf_rB_out <= '0;
        end else if (ifa.O_rf_enable) begin
            ifa.I_rf_rA_out <= rfa[ifa.O_rf_rA_select];
            ifa.I_rf_rB_out <= rfa[ifa.O_rf_rB_select];
            if (ifa.O_rf_rD_write) begin
                case (ifa.O_rf_write_pos)
                    2'd0: rfa[ifa.O_rf_rD_select]       <= ifa.O_rf_rD_in;
                    2'd1: rfa[ifa.O_rf_rD_select][7:0]  <= ifa.O_rf_rD_in[7:0];
                    2'd2: rfa[ifa.O_rf_rD_select][15:8] <= ifa.O_rf_rD_in[15:8];
                    default: ;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rfb[i] <= '0;
            ifb.I_rf_rA_out <= '0;
            ifb.I_rf_rB_out <= '0;
        end else if (ifb.O_rf_enable) begin
            ifb.I_rf_rA_out <= rfb[ifb.O_rf_rA_select];
            ifb.I_rf_rB_out <= rfb[ifb.O_rf_rB_select];
            if (ifb.O_rf_rD_write && ifb.O_rf_write_pos == 2'd0)
                rfb[ifb.O_rf_rD_select] <= ifb.O_rf_rD_in;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit inst, input logic [1:0] v);
        if (inst) ifb.I_req = v;
        else      ifa.I_req = v;
    endtask

    function automatic logic [1:0] ack_of(input bit inst);
        return inst ? ifb.O_ack : ifa.O_ack;
    endfunction

    function automatic logic busy_of(input bit inst);
        return inst ? ifb.O_busy : ifa.O_busy;
    endfunction

    // One access on instance A: starts from IDLE, expects ack three edges
    // after the request, drops req inside the ack cycle.
    task automatic access(input string tag, input bit port, input logic wr,
                          input logic [1:0] pos, input logic [2:0] rd,
                          input logic [2:0] ra, input logic [2:0] rb,
                          input logic [15:0] din, input bit chk_data,
                          input logic [15:0] exp_a, input logic [15:0] exp_b);
        int n;
        if (port) begin
            ifa.I_rD_sel1 = rd; ifa.I_rA_sel1 = ra; ifa.I_rB_sel1 = rb;
            ifa.I_rD_in1 = din; ifa.I_wr1 = wr; ifa.I_wr_pos1 = pos;
        end else begin
            ifa.I_rD_sel0 = rd; ifa.I_rA_sel0 = ra; ifa.I_rB_sel0 = rb;
            ifa.I_rD_in0 = din; ifa.I_wr0 = wr; ifa.I_wr_pos0 = pos;
        end
        ifa.I_req[port] = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                check_eq({tag, "_issue_en"}, 32'(ifa.O_rf_enable), 32'd1);
                check_eq({tag, "_issue_wr"}, 32'(ifa.O_rf_rD_write), 32'(wr));
            end
            if (n == 2) check_eq({tag, "_capture_en"}, 32'(ifa.O_rf_enable), 32'd0);
        end while (ifa.O_ack == 2'b00 && n < 12);
        check_eq({tag, "_latency"}, 32'(n), 32'd3);
        check_eq({tag, "_ack"}, 32'(ifa.O_ack), port ? 32'd2 : 32'd1);
        if (chk_data) begin
            check_eq({tag, "_rA"}, 32'(ifa.O_rA_data), 32'(exp_a));
            check_eq({tag, "_rB"}, 32'(ifa.O_rB_data), 32'(exp_b));
        end
        ifa.I_req[port] = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_idle"}, 32'(ifa.O_busy), 32'd0);
    endtask

    // Both ports request; expected winner of ack i is exp_ports[i].
    // Port 0 drops its request in the cycle of ack number drop0_at.
    task automatic contention(input string tag, input bit inst, input int n_acks,
                              input logic [7:0] exp_ports, input int drop0_at);
        int  gap;
        bit  busy_all;
        logic [1:0] req;
        req = 2'b11;
        set_req(inst, req);
        busy_all = 1'b1;
        for (int i = 0; i < n_acks; i++) begin
            gap = 0;
            do begin
                @(posedge clk); #1;
                gap++;
                if (!busy_of(inst)) busy_all = 1'b0;
            end while (ack_of(inst) == 2'b00 && gap < 12);
            check_eq($sformatf("%s_gap%0d", tag, i), 32'(gap), 32'd3);
            check_eq($sformatf("%s_ack%0d", tag, i), 32'(ack_of(inst)),
                     exp_ports[i] ? 32'd2 : 32'd1);
            if (i == drop0_at) begin
                req[0] = 1'b0;
                set_req(inst, req);
            end
        end
        set_req(inst, 2'b00);
        check_eq({tag, "_busy_held"}, 32'(busy_all), 32'd1);
        @(posedge clk); #1;
        check_eq({tag, "_idle"}, 32'(busy_of(inst)), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ifa.I_req = '0; ifa.I_rD_sel0 = '0; ifa.I_rD_sel1 = '0;
        ifa.I_rA_sel0 = '0; ifa.I_rA_sel1 = '0; ifa.I_rB_sel0 = '0;
        ifa.I_rB_sel1 = '0; ifa.I_rD_in0 = '0; ifa.I_rD_in1 = '0;
        ifa.I_wr0 = 1'b0; ifa.I_wr1 = 1'b0; ifa.I_wr_pos0 = '0; ifa.I_wr_pos1 = '0;
        ifb.I_req = '0; ifb.I_rD_sel0 = '0; ifb.I_rD_sel1 = '0;
        ifb.I_rA_sel0 = '0; ifb.I_rA_sel1 = '0; ifb.I_rB_sel0 = '0;
        ifb.I_rB_sel1 = '0; ifb.I_rD_in0 = '0; ifb.I_rD_in1 = '0;
        ifb.I_wr0 = 1'b0; ifb.I_wr1 = 1'b0; ifb.I_wr_pos0 = '0; ifb.I_wr_pos1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(ifa.O_busy), 32'd0);
        check_eq("rst_ack", 32'(ifa.O_ack), 32'd0);
        check_eq("rst_en", 32'(ifa.O_rf_enable), 32'd0);
        check_eq("rst_rA", 32'(ifa.O_rA_data), 32'd0);
        check_eq("rst_fp_busy", 32'(ifb.O_busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Round-robin contention straight out of reset: port 0 first.
        contention("rr", 1'b0, 4, 8'b0000_1010, -1);
        // Fixed priority: port 0 served until it drops, then port 1.
        contention("fp", 1'b1, 4, 8'b0000_1000, 2);

        // Preload via full-word writes.
        access("pre2", 1'b0, 1'b1, 2'd0, 3'd2, 3'd0, 3'd0, 16'h1234, 1'b0, '0, '0);
        access("pre5", 1'b0, 1'b1, 2'd0, 3'd5, 3'd0, 3'd0, 16'hBEEF, 1'b0, '0, '0);
        access("pre3", 1'b1, 1'b1, 2'd0, 3'd3, 3'd0, 3'd0, 16'h1111, 1'b0, '0, '0);
        access("pre4", 1'b0, 1'b1, 2'd0, 3'd4, 3'd0, 3'd0, 16'h0001, 1'b0, '0, '0);

        // Single read.
        access("rd25", 1'b0, 1'b0, 2'd0, 3'd0, 3'd2, 3'd5, 16'h0000, 1'b1,
               16'h1234, 16'hBEEF);
        @(posedge clk); #1;
        check_eq("hold_rA", 32'(ifa.O_rA_data), 32'h1234);
        check_eq("idle_en", 32'(ifa.O_rf_enable), 32'd0);

        // Byte writes on port 1; each access also reads r3 before its write.
        access("wlo", 1'b1, 1'b1, 2'd1, 3'd3, 3'd3, 3'd2, 16'h00AA, 1'b1,
               16'h1111, 16'h1234);
        access("whi", 1'b1, 1'b1, 2'd2, 3'd3, 3'd3, 3'd2, 16'hCC00, 1'b1,
               16'h11AA, 16'h1234);
        access("wnone", 1'b1, 1'b1, 2'd3, 3'd3, 3'd3, 3'd2, 16'hFFFF, 1'b1,
               16'hCCAA, 16'h1234);
        access("rd3", 1'b1, 1'b0, 2'd0, 3'd0, 3'd3, 3'd3, 16'h0000, 1'b1,
               16'hCCAA, 16'hCCAA);

        // Read-during-write returns the old value.
        access("rdw", 1'b0, 1'b1, 2'd0, 3'd4, 3'd4, 3'd5, 16'h5555, 1'b1,
               16'h0001, 16'hBEEF);
        access("rd4", 1'b0, 1'b0, 2'd0, 3'd0, 3'd4, 3'd4, 16'h0000, 1'b1,
               16'h5555, 16'h5555);

        // Reset while a write to r6 is in ISSUE.
        ifa.I_rD_sel0 = 3'd6; ifa.I_rA_sel0 = 3'd0; ifa.I_rB_sel0 = 3'd0;
        ifa.I_rD_in0 = 16'hDEAD; ifa.I_wr0 = 1'b1; ifa.I_wr_pos0 = 2'd0;
        ifa.I_req = 2'b01;
        @(posedge clk); #1;
        check_eq("r6_issue_en", 32'(ifa.O_rf_enable), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("r6_rst_en", 32'(ifa.O_rf_enable), 32'd0);
        check_eq("r6_rst_wr", 32'(ifa.O_rf_rD_write), 32'd0);
        check_eq("r6_rst_ack", 32'(ifa.O_ack), 32'd0);
        check_eq("r6_rst_busy", 32'(ifa.O_busy), 32'd0);
        check_eq("r6_rst_rA", 32'(ifa.O_rA_data), 32'd0);
        ifa.I_req = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access("rd6", 1'b0, 1'b0, 2'd0, 3'd0, 3'd6, 3'd6, 16'h0000, 1'b1,
               16'h0000, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
